// File: rtl/dg_pkg.sv
// Shared header widths, header struct and arbiter FSM states for the data_gen
// path (dg_fetch, dg_hdr_arbiter, data_gen).
package dg_pkg;

    localparam int DA_W   = 4;
    localparam int PRIO_W = 3;
    localparam int LEN_W  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DA_W-1:0]   da;
        logic [PRIO_W-1:0] prior;
        logic [LEN_W-1:0]  len;
    } hdr_t;

endpackage

// File: rtl/dg_hdr_arbiter_rr_prio_pick.sv
// Combinational winner pick: optionally keeps only the highest-priority valid
// requesters, then takes the first one found scanning from rr_ptr upwards.
module rr_prio_pick
    import dg_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter bit PRIO_EN = 1'b1,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]        vld,
    input  logic [PRIO_W*N_REQ-1:0] prior,
    input  logic [IDX_W-1:0]        rr_ptr,
    output logic [N_REQ-1:0]        grant,
    output logic [IDX_W-1:0]        idx,
    output logic                    any
);

    logic [PRIO_W-1:0] prio_arr [N_REQ];
    logic [PRIO_W-1:0] max_prio;
    logic [N_REQ-1:0]  cand;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign prio_arr[gi] = prior[gi*PRIO_W +: PRIO_W];
            assign cand[gi]     = vld[gi] && (!PRIO_EN || (prio_arr[gi] == max_prio));
        end
    endgenerate

    always_comb begin
        max_prio = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vld[i] && (prio_arr[i] > max_prio)) begin
                max_prio = prio_arr[i];
            end
        end
    end

    // Rotating scan; rr_ptr is always below N_REQ, so the modulo handles non-power-of-two N_REQ.
    always_comb begin
        int  j;
        logic found;
        j     = 0;
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(rr_ptr) + k) % N_REQ;
            if (!found && cand[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

    assign any = |cand;

endmodule

// File: rtl/dg_hdr_arbiter.sv
// Shares one data_gen engine among N_REQ header sources: accept a winner,
// issue its header on vld/ready, hold the grant until the engine's eop.
module dg_hdr_arbiter
    import dg_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter bit PRIO_EN = 1'b1,
    parameter int CNT_W   = 16,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        i_req_vld,
    input  logic [DA_W*N_REQ-1:0]   i_req_da,
    input  logic [PRIO_W*N_REQ-1:0] i_req_prior,
    input  logic [LEN_W*N_REQ-1:0]  i_req_len,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic [DA_W-1:0]         o_da,
    output logic [PRIO_W-1:0]       o_prior,
    output logic [LEN_W-1:0]        o_len,
    output logic                    o_vld,
    input  logic                    i_gen_ready,
    input  logic                    i_eop,
    output logic [IDX_W-1:0]        o_grant_id,
    output logic                    o_busy,
    output logic [CNT_W-1:0]        o_pkt_cnt
);

    state_t            state_reg;
    state_t            state_next;
    logic [IDX_W-1:0]  rr_ptr_reg;
    logic [IDX_W-1:0]  grant_id_reg;
    logic [CNT_W-1:0]  pkt_cnt_reg;
    hdr_t              hdr_reg;

    logic [N_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    hdr_t              hdr_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_hdr
            assign hdr_arr[gi].da    = i_req_da[gi*DA_W +: DA_W];
            assign hdr_arr[gi].prior = i_req_prior[gi*PRIO_W +: PRIO_W];
            assign hdr_arr[gi].len   = i_req_len[gi*LEN_W +: LEN_W];
        end
    endgenerate

    rr_prio_pick #(
        .N_REQ   (N_REQ),
        .PRIO_EN (PRIO_EN)
    ) u_pick (
        .vld    (i_req_vld),
        .prior  (i_req_prior),
        .rr_ptr (rr_ptr_reg),
        .grant  (pick_grant),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_any)    state_next = ISSUE;
            ISSUE:   if (i_gen_ready) state_next = BUSY;
            BUSY:    if (i_eop)       state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // The accept strobe is combinational; masking with rst_n keeps it quiet while reset is held.
    always_comb begin
        o_req_ready = '0;
        if (rst_n && (state_reg == IDLE)) begin
            o_req_ready = pick_grant;
        end
        o_vld  = (state_reg == ISSUE);
        o_busy = (state_reg != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_reg   <= '0;
            grant_id_reg <= '0;
            pkt_cnt_reg  <= '0;
            hdr_reg      <= '0;
        end else begin
            if ((state_reg == IDLE) && pick_any) begin
                hdr_reg      <= hdr_arr[pick_idx];
                grant_id_reg <= pick_idx;
            end
            // Pointer moves past the owner only when its packet completes.
            if ((state_reg == BUSY) && i_eop) begin
                pkt_cnt_reg <= pkt_cnt_reg + CNT_W'(1);
                rr_ptr_reg  <= (grant_id_reg == IDX_W'(N_REQ - 1)) ? '0 : grant_id_reg + IDX_W'(1);
            end
        end
    end

    assign o_da       = hdr_reg.da;
    assign o_prior    = hdr_reg.prior;
    assign o_len      = hdr_reg.len;
    assign o_grant_id = grant_id_reg;
    assign o_pkt_cnt  = pkt_cnt_reg;

endmodule

// File: tb/tb_dg_hdr_arbiter.sv
// Bench for dg_hdr_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a packet-level model.
module tb_dg_hdr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_vld = '0;
    logic [15:0] req_da = '0;
    logic [11:0] req_prior = '0;
    logic [39:0] req_len = '0;
    logic [3:0]  req_ready;
    logic [3:0]  da;
    logic [2:0]  prior;
    logic [9:0]  len;
    logic        vld;
    logic        gen_ready = 1'b0;
    logic        eop = 1'b0;
    logic [1:0]  grant_id;
    logic        busy;
    logic [3:0]  pkt_cnt;

    always #5 clk = ~clk;

    dg_hdr_arbiter #(
        .N_REQ   (4),
        .PRIO_EN (1'b1),
        .CNT_W   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_vld   (req_vld),
        .i_req_da    (req_da),
        .i_req_prior (req_prior),
        .i_req_len   (req_len),
        .o_req_ready (req_ready),
        .o_da        (da),
        .o_prior     (prior),
        .o_len       (len),
        .o_vld       (vld),
        .i_gen_ready (gen_ready),
        .i_eop       (eop),
        .o_grant_id  (grant_id),
        .o_busy      (busy),
        .o_pkt_cnt   (pkt_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Packet-level model: who owns the engine, whether its header was taken, what it carries.
    int          m_owner  = -1;
    bit          m_issued = 1'b0;
    logic [3:0]  m_da     = '0;
    logic [2:0]  m_prior  = '0;
    logic [9:0]  m_len    = '0;
    int          m_rr     = 0;
    int          m_cnt    = 0;
    int          m_gid    = 0;
    logic [3:0]  m_acc    = '0;
    bit          model_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input logic [11:0] p, input int rr);
        int mx;
        int j;
        mx = -1;
        for (int i = 0; i < 4; i++)
            if (v[i] && int'(p[i*3 +: 3]) > mx) mx = int'(p[i*3 +: 3]);
        for (int k = 0; k < 4; k++) begin
            j = (rr + k) % 4;
            if (v[j] && int'(p[j*3 +: 3]) == mx) return j;
        end
        return -1;
    endfunction

    task automatic model_check();
        int         w;
        logic [3:0] er;
        bit         idle;
        if (!model_on) return;
        idle = (m_owner < 0);
        w    = pick(req_vld, req_prior, m_rr);
        er   = '0;
        if (rst_n && idle && w >= 0) er[w] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("o_vld", vld, !idle && !m_issued);
        chk("o_busy", busy, !idle);
        chk("o_da", da, m_da);
        chk("o_prior", prior, m_prior);
        chk("o_len", len, m_len);
        chk("o_grant_id", grant_id, m_gid);
        chk("o_pkt_cnt", pkt_cnt, m_cnt);
        m_acc = er;
        if (!rst_n) begin
            m_owner = -1; m_issued = 0; m_da = '0; m_prior = '0; m_len = '0;
            m_rr = 0; m_cnt = 0; m_gid = 0;
        end else if (idle) begin
            if (w >= 0) begin
                m_owner = w; m_issued = 0; m_gid = w;
                m_da = req_da[w*4 +: 4]; m_prior = req_prior[w*3 +: 3]; m_len = req_len[w*10 +: 10];
            end
        end else if (!m_issued) begin
            if (gen_ready) m_issued = 1;
        end else if (eop) begin
            m_cnt   = (m_cnt + 1) % 16;
            m_rr    = (m_owner + 1) % 4;
            m_owner = -1;
        end
    endtask

    // One clock: model compare on the falling edge, then land just after the rising edge.
    task automatic cyc();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_vld = '0; gen_ready = 1'b0; eop = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for an accept, require it to go to exp_id, then run that packet to eop.
    task automatic serve(input int exp_id, input bit keep);
        int n;
        n = 0;
        #1;
        while (req_ready == 4'b0 && n < 10) begin
            cyc(); #1; n++;
        end
        chk("grant_onehot", req_ready, 32'd1 << exp_id);
        cyc();
        if (!keep) req_vld[exp_id] = 1'b0;
        gen_ready = 1'b1;
        cyc();
        eop = 1'b1;
        cyc();
        eop = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        model_on = 1'b1;

        // Single requester, literal header and latency.
        do_reset(); #1;
        chk("rst_busy", busy, 0); chk("rst_cnt", pkt_cnt, 0); chk("rst_vld", vld, 0);
        chk("rst_ready", req_ready, 0); chk("rst_da", da, 0);
        req_vld = 4'b0001; req_da[3:0] = 4'd3; req_prior[2:0] = 3'd2; req_len[9:0] = 10'd64;
        gen_ready = 1'b1; #1;
        chk("t1_ready", req_ready, 4'b0001);
        cyc(); req_vld[0] = 1'b0; #1;
        chk("t1_vld", vld, 1); chk("t1_da", da, 3); chk("t1_len", len, 64);
        chk("t1_prior", prior, 2); chk("t1_gid", grant_id, 0);
        cyc(); #1;
        chk("t1_vld_drop", vld, 0); chk("t1_busy", busy, 1);
        eop = 1'b1; cyc(); eop = 1'b0; #1;
        chk("t1_cnt", pkt_cnt, 1); chk("t1_idle", busy, 0);

        // Equal priorities held continuously: plain round robin 0,1,2,3,0.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req_da[k*4 +: 4] = 4'(k + 8); req_prior[k*3 +: 3] = 3'd4; req_len[k*10 +: 10] = 10'(k * 10 + 1);
        end
        req_vld = 4'hf;
        serve(0, 1); serve(1, 1); serve(2, 1); serve(3, 1); serve(0, 1);
        req_vld = '0; #1;
        chk("t2_cnt", pkt_cnt, 5);

        // Priority: req2 and req3 at 7 beat req1 at 5; tie broken by rotation.
        req_prior[5:3] = 3'd5; req_prior[8:6] = 3'd7; req_prior[11:9] = 3'd7;
        req_vld = 4'b1110;
        serve(2, 0); serve(3, 0); serve(1, 0);

        // Engine stall in ISSUE with competing requests and a stray eop.
        req_vld = 4'b0001; req_prior[2:0] = 3'd1; req_da[3:0] = 4'd9; req_len[9:0] = 10'd500;
        gen_ready = 1'b0;
        cyc();
        req_vld = 4'b0110; eop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_vld", vld, 1); chk("t4_da", da, 9); chk("t4_len", len, 500); chk("t4_ready", req_ready, 0);
            cyc();
        end
        eop = 1'b0; gen_ready = 1'b1;
        cyc();
        eop = 1'b1; cyc(); eop = 1'b0;
        serve(2, 0); serve(1, 0);

        // Reset while BUSY drops everything; the still-pending req0 wins again afterwards.
        req_vld = 4'b0001; gen_ready = 1'b1;
        cyc(); cyc(); #1;
        chk("t5_busy_pre", busy, 1);
        rst_n = 1'b0; cyc(); #1;
        chk("t5_busy", busy, 0); chk("t5_vld", vld, 0); chk("t5_ready", req_ready, 0);
        chk("t5_cnt", pkt_cnt, 0); chk("t5_da", da, 0); chk("t5_len", len, 0); chk("t5_gid", grant_id, 0);
        rst_n = 1'b1; #1;
        chk("t5_reaccept", req_ready, 4'b0001);
        serve(0, 0);

        // Four-bit counter wraps after 16 packets.
        do_reset();
        req_vld = 4'b0001;
        repeat (17) serve(0, 1);
        req_vld = '0; #1;
        chk("t6_wrap", pkt_cnt, 1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (m_acc[k]) begin
                    req_vld[k] = 1'b0;
                end else if (!req_vld[k] && $urandom_range(0, 3) == 0) begin
                    req_vld[k] = 1'b1;
                    req_da[k*4 +: 4] = 4'($urandom);
                    req_prior[k*3 +: 3] = ($urandom_range(0, 1) == 1) ? 3'd7 : 3'($urandom_range(0, 7));
                    req_len[k*10 +: 10] = 10'($urandom);
                end else if (req_vld[k] && $urandom_range(0, 31) == 0) begin
                    req_vld[k] = 1'b0;
                end
            end
            gen_ready = ($urandom_range(0, 2) != 0);
            eop       = ($urandom_range(0, 3) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
